// File: rtl/reliability_event_logger.sv
// reliability_event_logger: timestamps rising edges of reliability flags into a show-ahead FIFO with sticky status and saturating counts
module reliability_event_logger #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 16,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     log_en,
   input  logic                     clr_stat,
   input  logic                     alu_fault_in,
   input  logic                     mux_fault_in,
   input  logic                     ecc_err_in,
   input  logic                     evt_pop,
   output logic                     evt_valid,
   output logic [TS_W-1:0]          evt_ts,
   output logic [2:0]               evt_src,
   output logic [$clog2(DEPTH):0]   evt_count,
   output logic [2:0]               sticky,
   output logic                     any_fault,
   output logic [CNT_W-1:0]         alu_cnt,
   output logic [CNT_W-1:0]         mux_cnt,
   output logic [CNT_W-1:0]         ecc_cnt,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [2:0]      prev, rise, logged;
   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] ts_mem [DEPTH];
   logic [2:0]      src_mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic            push, pop, full, accept, drop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return v + CNT_W'(inc && v != '1);
   endfunction

   always_comb begin
      rise      = {ecc_err_in, mux_fault_in, alu_fault_in} & ~prev;
      logged    = log_en ? rise : 3'b000;
      push      = |logged;
      evt_valid = evt_count != '0;
      full      = evt_count == CW'(DEPTH);
      pop       = evt_pop && evt_valid;
      accept    = push && (!full || pop);
      drop      = push && full && !pop;
      evt_ts    = evt_valid ? ts_mem[rd_ptr] : '0;
      evt_src   = evt_valid ? src_mem[rd_ptr] : '0;
      any_fault = |sticky;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev      <= '0;
         ts        <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         evt_count <= '0;
         sticky    <= '0;
         alu_cnt   <= '0;
         mux_cnt   <= '0;
         ecc_cnt   <= '0;
         overflow  <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         prev      <= {ecc_err_in, mux_fault_in, alu_fault_in};
         ts        <= ts + 1'b1;
         rd_ptr    <= rd_ptr + AW'(pop);
         wr_ptr    <= wr_ptr + AW'(accept);
         evt_count <= evt_count + CW'(accept) - CW'(pop);
         // a clear coinciding with a new edge keeps the new edge
         sticky    <= (clr_stat ? 3'b000 : sticky) | logged;
         alu_cnt   <= clr_stat ? CNT_W'(logged[0]) : sat_inc(alu_cnt, logged[0]);
         mux_cnt   <= clr_stat ? CNT_W'(logged[1]) : sat_inc(mux_cnt, logged[1]);
         ecc_cnt   <= clr_stat ? CNT_W'(logged[2]) : sat_inc(ecc_cnt, logged[2]);
         overflow  <= (overflow & ~clr_stat) | drop;
         drop_cnt  <= clr_stat ? CNT_W'(drop) : sat_inc(drop_cnt, drop);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         ts_mem[wr_ptr]  <= ts;
         src_mem[wr_ptr] <= rise;
      end
   end
endmodule

// File: tb/tb_reliability_event_logger.sv
// tb_reliability_event_logger: directed checks of the event logger, with a narrow-timestamp/narrow-counter twin instance
module tb_reliability_event_logger;
   logic        clk = 1'b0;
   logic        rst, log_en, clr_stat, alu, mux, ecc, evt_pop;
   logic        evt_valid, any_fault, overflow;
   logic [15:0] evt_ts;
   logic [2:0]  evt_src, sticky;
   logic [3:0]  evt_count;
   logic [7:0]  alu_cnt, mux_cnt, ecc_cnt, drop_cnt;
   logic        w_valid, w_any, w_ovf;
   logic [3:0]  w_ts;
   logic [2:0]  w_src, w_sticky;
   logic [3:0]  w_count;
   logic [1:0]  w_alu_cnt, w_mux_cnt, w_ecc_cnt, w_drop_cnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   reliability_event_logger dut (
      .clk(clk), .rst(rst), .log_en(log_en), .clr_stat(clr_stat),
      .alu_fault_in(alu), .mux_fault_in(mux), .ecc_err_in(ecc), .evt_pop(evt_pop),
      .evt_valid(evt_valid), .evt_ts(evt_ts), .evt_src(evt_src), .evt_count(evt_count),
      .sticky(sticky), .any_fault(any_fault), .alu_cnt(alu_cnt), .mux_cnt(mux_cnt),
      .ecc_cnt(ecc_cnt), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   reliability_event_logger #(.DEPTH(8), .TS_W(4), .CNT_W(2)) dut_w (
      .clk(clk), .rst(rst), .log_en(log_en), .clr_stat(clr_stat),
      .alu_fault_in(alu), .mux_fault_in(mux), .ecc_err_in(ecc), .evt_pop(evt_pop),
      .evt_valid(w_valid), .evt_ts(w_ts), .evt_src(w_src), .evt_count(w_count),
      .sticky(w_sticky), .any_fault(w_any), .alu_cnt(w_alu_cnt), .mux_cnt(w_mux_cnt),
      .ecc_cnt(w_ecc_cnt), .overflow(w_ovf), .drop_cnt(w_drop_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; log_en = 1'b0; clr_stat = 1'b0;
      alu = 1'b0; mux = 1'b0; ecc = 1'b0; evt_pop = 1'b0;
      step(); step();
      chk("rst_valid", 32'(evt_valid), 0);
      chk("rst_count", 32'(evt_count), 0);
      chk("rst_sticky", 32'(sticky), 0);
      chk("rst_any", 32'(any_fault), 0);
      chk("rst_ts", 32'(evt_ts), 0);
      chk("rst_src", 32'(evt_src), 0);
      chk("rst_cnts", {alu_cnt, mux_cnt, ecc_cnt, drop_cnt}, 0);
      chk("rst_ovf", 32'(overflow), 0);
      // single event at ts=10, held 5 cycles
      rst = 1'b0; log_en = 1'b1;
      repeat (10) step();
      ecc = 1'b1; step();
      chk("single_valid", 32'(evt_valid), 1);
      chk("single_ts", 32'(evt_ts), 10);
      chk("single_src", 32'(evt_src), 4);
      chk("single_sticky", 32'(sticky), 4);
      chk("single_ecc_cnt", 32'(ecc_cnt), 1);
      chk("single_any", 32'(any_fault), 1);
      repeat (4) step();
      ecc = 1'b0; step();
      chk("single_level_count", 32'(evt_count), 1);
      evt_pop = 1'b1; step(); evt_pop = 1'b0;
      chk("single_popped", 32'(evt_valid), 0);
      // merged sources at ts=17
      alu = 1'b1; mux = 1'b1; step();
      chk("merge_src", 32'(evt_src), 3);
      chk("merge_ts", 32'(evt_ts), 17);
      chk("merge_cnts", {alu_cnt, mux_cnt}, 32'h0101);
      chk("merge_count", 32'(evt_count), 1);
      chk("merge_sticky", 32'(sticky), 7);
      alu = 1'b0; mux = 1'b0; step();
      evt_pop = 1'b1; step(); evt_pop = 1'b0;
      clr_stat = 1'b1; step(); clr_stat = 1'b0;
      chk("clr_stat", {8'(sticky), alu_cnt, mux_cnt, ecc_cnt}, 0);
      // overflow: ten pulses at ts 21,23,...,39
      for (int i = 0; i < 10; i++) begin
         alu = 1'b1; step();
         alu = 1'b0; step();
      end
      chk("ovf_count", 32'(evt_count), 8);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_drop", 32'(drop_cnt), 2);
      chk("ovf_alu_cnt", 32'(alu_cnt), 10);
      chk("sat_alu_cnt", 32'(w_alu_cnt), 3);
      chk("sat_drop_cnt", 32'(w_drop_cnt), 2);
      // full boundary: pop and push together at ts=41
      alu = 1'b1; evt_pop = 1'b1; step();
      alu = 1'b0; evt_pop = 1'b0;
      chk("full_pp_count", 32'(evt_count), 8);
      chk("full_pp_drop", 32'(drop_cnt), 2);
      chk("full_pp_alu_cnt", 32'(alu_cnt), 11);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_ts%0d", i), 32'(evt_ts), (i < 7) ? 23 + 2 * i : 41);
         evt_pop = 1'b1; step(); evt_pop = 1'b0;
      end
      chk("drain_valid", 32'(evt_valid), 0);
      chk("drain_count", 32'(evt_count), 0);
      evt_pop = 1'b1; step(); evt_pop = 1'b0;
      chk("empty_pop_count", 32'(evt_count), 0);
      // empty: pop ignored, push accepted at ts=51
      alu = 1'b1; evt_pop = 1'b1; step();
      alu = 1'b0; evt_pop = 1'b0;
      chk("empty_pp_count", 32'(evt_count), 1);
      chk("empty_pp_ts", 32'(evt_ts), 51);
      step();
      // clear in the same cycle as a mux rise
      mux = 1'b1; clr_stat = 1'b1; step();
      mux = 1'b0; clr_stat = 1'b0;
      chk("clr_edge_sticky", 32'(sticky), 2);
      chk("clr_edge_cnts", {alu_cnt, mux_cnt, ecc_cnt}, 32'h000100);
      chk("clr_edge_ovf", {overflow, drop_cnt}, 0);
      chk("clr_edge_fifo", {evt_count, evt_ts}, {4'd2, 16'd51});
      log_en = 1'b0; alu = 1'b1; mux = 1'b1; ecc = 1'b1; step();
      alu = 1'b0; mux = 1'b0; ecc = 1'b0; step();
      log_en = 1'b1;
      chk("dis_count", 32'(evt_count), 2);
      chk("dis_cnts", {alu_cnt, mux_cnt, ecc_cnt}, 32'h000100);
      chk("dis_sticky", 32'(sticky), 2);
      // reset mid-operation with alu held high
      ecc = 1'b1; step(); ecc = 1'b0; step();
      chk("pre_rst_count", 32'(evt_count), 3);
      alu = 1'b1; rst = 1'b1; step();
      chk("mid_rst_state", {evt_count, 3'(sticky), evt_valid, alu_cnt}, 0);
      chk("mid_rst_head", {evt_ts, 13'(evt_src)}, 0);
      rst = 1'b0; step();
      chk("post_rst_count", 32'(evt_count), 1);
      chk("post_rst_head", {evt_ts, 13'(evt_src)}, {16'd0, 13'd1});
      chk("post_rst_alu_cnt", 32'(alu_cnt), 1);
      repeat (3) step();
      chk("level_count", 32'(evt_count), 1);
      // timestamp wrap at cycle 17
      alu = 1'b0; rst = 1'b1; step(); rst = 1'b0;
      repeat (17) step();
      alu = 1'b1; step(); alu = 1'b0;
      chk("wrap_ts_w4", 32'(w_ts), 1);
      chk("wrap_ts_w16", 32'(evt_ts), 17);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
